// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mem_stage_pkg
// Purpose  : EX_MEM bundle field offsets and MemToReg encodings, shared with EX.
// Revision : 1.0
// ============================================================================
package mem_stage_pkg;

    localparam int EX_MEM_W  = 139;
    localparam int WDATA_LSB = 0;
    localparam int ALUS_LSB  = 32;
    localparam int WREG_LSB  = 64;
    localparam int MEMRD     = 69;
    localparam int MEMWR     = 70;
    localparam int REGWR     = 71;
    localparam int M2R_LSB   = 72;
    localparam int PC4_LSB   = 74;
    localparam int LUD_LSB   = 106;
    localparam int LUOP      = 138;

    localparam logic [1:0] M2R_ALU  = 2'b00;
    localparam logic [1:0] M2R_MEM  = 2'b01;
    localparam logic [1:0] M2R_PC4  = 2'b10;
    localparam logic [1:0] M2R_ZERO = 2'b11;

    // Write-back source select; the forwarding path passes ALU_S as mem_val.
    function automatic logic [31:0] wb_select(
        input logic        luop,
        input logic [31:0] lu_data,
        input logic [1:0]  mem_to_reg,
        input logic [31:0] alu_s,
        input logic [31:0] mem_val,
        input logic [31:0] pc_plus4
    );
        logic [31:0] v;
        v = '0;
        if (luop) begin
            v = lu_data;
        end else begin
            case (mem_to_reg)
                M2R_ALU: v = alu_s;
                M2R_MEM: v = mem_val;
                M2R_PC4: v = pc_plus4;
                default: v = '0;
            endcase
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Purpose  : req/ack handshake FSM with timeout counter; produces stall and done.
// Revision : 1.0
// ============================================================================
module mem_access_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset_b,
    input  logic access,
    input  logic mem_ack,
    output logic mem_req,
    output logic stall,
    output logic done,
    output logic timeout
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_ack;
    logic             w_expire;

    // An ack only counts while a request is actually being presented.
    assign w_ack    = access & mem_ack;
    assign w_expire = (r_state == S_BUSY) && (r_count == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            r_state <= S_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = '0;
        case (r_state)
            S_IDLE: begin
                if (access && !w_ack) w_state_nxt = S_BUSY;
            end
            S_BUSY: begin
                if (w_ack || w_expire) w_state_nxt = S_IDLE;
                else                   w_count_nxt = r_count + 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req = access;
        done    = w_ack | w_expire;
        stall   = access & ~(w_ack | w_expire);
        timeout = w_expire & ~w_ack;
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : MEM pipeline stage: data-memory port, write-back select, MEM_WB register.
// Revision : 1.0
// ============================================================================
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset_b,
    input  logic [EX_MEM_W-1:0] EX_MEM,
    output logic [4:0]          EX_MEM_Rd,
    output logic                EX_MEM_RegWrite,
    output logic [31:0]         EX_MEM_RdData,
    output logic                mem_req,
    output logic                mem_we,
    output logic [31:0]         mem_addr,
    output logic [31:0]         mem_wdata,
    input  logic [31:0]         mem_rdata,
    input  logic                mem_ack,
    output logic                stall,
    output logic                MEM_WB_RegWrite,
    output logic [4:0]          MEM_WB_WriteReg,
    output logic [31:0]         MEM_WB_RegWriteData,
    output logic                bus_err,
    output logic                misalign_err
);

    logic [31:0] w_wdata, w_alu_s, w_pc4, w_lud;
    logic [4:0]  w_wreg;
    logic [1:0]  w_m2r;
    logic        w_memrd, w_memwr, w_regwr, w_luop;
    logic        w_mem_op, w_access, w_misaligned;
    logic        w_done, w_timeout;
    logic [31:0] w_mem_val, w_wb_data;

    logic        r_wb_regwrite;
    logic [4:0]  r_wb_writereg;
    logic [31:0] r_wb_data;
    logic        r_bus_err;
    logic        r_misalign_err;

    assign w_wdata = EX_MEM[WDATA_LSB +: 32];
    assign w_alu_s = EX_MEM[ALUS_LSB  +: 32];
    assign w_wreg  = EX_MEM[WREG_LSB  +: 5];
    assign w_memrd = EX_MEM[MEMRD];
    assign w_memwr = EX_MEM[MEMWR];
    assign w_regwr = EX_MEM[REGWR];
    assign w_m2r   = EX_MEM[M2R_LSB   +: 2];
    assign w_pc4   = EX_MEM[PC4_LSB   +: 32];
    assign w_lud   = EX_MEM[LUD_LSB   +: 32];
    assign w_luop  = EX_MEM[LUOP];

    assign w_mem_op     = w_memrd | w_memwr;
    assign w_access     = w_mem_op & (w_alu_s[1:0] == 2'b00);
    assign w_misaligned = w_mem_op & (w_alu_s[1:0] != 2'b00);

    mem_access_ctrl #(
        .TIMEOUT (TIMEOUT)
    ) u_ctrl (
        .clk     (clk),
        .reset_b (reset_b),
        .access  (w_access),
        .mem_ack (mem_ack),
        .mem_req (mem_req),
        .stall   (stall),
        .done    (w_done),
        .timeout (w_timeout)
    );

    // A timed-out access completes with zero read data.
    assign w_mem_val = (w_done && !w_timeout) ? mem_rdata : 32'h0;
    assign w_wb_data = wb_select(w_luop, w_lud, w_m2r, w_alu_s, w_mem_val, w_pc4);

    assign mem_we    = w_memwr;
    assign mem_addr  = w_alu_s;
    assign mem_wdata = w_wdata;

    assign EX_MEM_Rd       = w_wreg;
    assign EX_MEM_RegWrite = w_regwr;
    assign EX_MEM_RdData   = wb_select(w_luop, w_lud, w_m2r, w_alu_s, w_alu_s, w_pc4);

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            r_wb_regwrite  <= 1'b0;
            r_wb_writereg  <= '0;
            r_wb_data      <= '0;
            r_bus_err      <= 1'b0;
            r_misalign_err <= 1'b0;
        end else begin
            if (stall) begin
                r_wb_regwrite <= 1'b0;
                r_wb_writereg <= '0;
                r_wb_data     <= '0;
            end else begin
                r_wb_regwrite <= w_regwr & ~w_misaligned;
                r_wb_writereg <= w_wreg;
                r_wb_data     <= w_wb_data;
            end
            if (w_timeout)    r_bus_err      <= 1'b1;
            if (w_misaligned) r_misalign_err <= 1'b1;
        end
    end

    assign MEM_WB_RegWrite     = r_wb_regwrite;
    assign MEM_WB_WriteReg     = r_wb_writereg;
    assign MEM_WB_RegWriteData = r_wb_data;
    assign bus_err             = r_bus_err;
    assign misalign_err        = r_misalign_err;

endmodule
`default_nettype wire
